ncl_addr_receiver: RTL

- Clocked consumer at the far end of the dual-rail NCL address channel driven by the PH0-gated address enable stage.
- Synchronises the asynchronous 4-bit dual-rail address (4-phase, return-to-NULL), detects a settled complete DATA wavefront and hands a binary address to synchronous logic with valid/ready.
- Drives the acknowledge back to the producer: high requests NULL, low requests DATA.
- Bridges the self-timed CPU core to a clocked memory/ROM model.

---
 rtl/ncl_pkg.sv | 45 ++++
 rtl/ncl_sync_bank.sv | 28 ++
 rtl/ncl_addr_receiver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ncl_pkg.sv
// Shared definitions for the clocked NCL address receiver: rail codes, FSM states
// and helpers that classify and decode a 4-pair dual-rail word.
package ncl_pkg;

    localparam logic [1:0] NCL_NULL  = 2'b00;
    localparam logic [1:0] NCL_TRUE  = 2'b10;
    localparam logic [1:0] NCL_FALSE = 2'b01;
    localparam logic [1:0] NCL_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RTN     = 2'd2
    } state_t;

    function automatic logic is_complete(input logic [7:0] word);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (word[2*i +: 2] != NCL_TRUE && word[2*i +: 2] != NCL_FALSE) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic is_null(input logic [7:0] word);
        return word == 8'h00;
    endfunction

    function automatic logic has_illegal(input logic [7:0] word);
        logic ill;
        ill = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (word[2*i +: 2] == NCL_ILL) ill = 1'b1;
        end
        return ill;
    endfunction

    // The true rail of each pair carries the binary bit.
    function automatic logic [3:0] decode(input logic [7:0] word);
        logic [3:0] bin;
        for (int i = 0; i < 4; i++) bin[i] = word[2*i+1];
        return bin;
    endfunction

endpackage

// File: rtl/ncl_sync_bank.sv
// Multi-stage flop synchroniser for the 8 asynchronous address rails,
// cleared synchronously by an active-low reset.
module ncl_sync_bank #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    output logic [7:0] q
);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [SYNC_STAGES-1:0][7:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_addr_receiver.sv
// Clocked receiver for a 4-phase dual-rail NCL address: synchronises the rails,
// waits for a settled DATA/NULL wavefront and presents the address with valid/ready.
module ncl_addr_receiver
    import ncl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr_in,
    output logic       ack_out,
    output logic [3:0] addr_o,
    output logic       addr_valid,
    input  logic       addr_ready,
    output logic       err_illegal,
    output logic       err_proto
);

    localparam int              CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    logic [7:0]       word;
    state_t           state_q, state_d;
    logic [7:0]       prev_q, prev_d;
    logic [7:0]       cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       addr_q, addr_d;
    logic             valid_q, valid_d;
    logic             ack_q, ack_d;
    logic             err_ill_q, err_ill_d;
    logic             err_proto_q, err_proto_d;
    logic             on_target;
    logic             settled;

    ncl_sync_bank #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (addr_in),
        .q     (word)
    );

    always_comb begin
        state_d     = state_q;
        prev_d      = word;
        cap_d       = cap_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        ack_d       = ack_q;
        err_ill_d   = err_ill_q | has_illegal(word);
        err_proto_d = err_proto_q;

        // The wavefront being waited for depends on which half of the handshake we are in.
        on_target = (state_q == RTN) ? is_null(word) : is_complete(word);
        if (on_target && word == prev_q)
            cnt_d = (cnt_q == SETTLE_C) ? cnt_q : cnt_q + CNT_W'(1);
        else
            cnt_d = '0;
        settled = (cnt_d == SETTLE_C);

        case (state_q)
            IDLE: begin
                if (settled) begin
                    addr_d  = decode(word);
                    cap_d   = word;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (word != cap_q) err_proto_d = 1'b1;
                if (addr_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = RTN;
                end
            end
            RTN: begin
                if (settled) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            cap_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            ack_q       <= 1'b0;
            err_ill_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            ack_q       <= ack_d;
            err_ill_q   <= err_ill_d;
            err_proto_q <= err_proto_d;
        end
    end

    assign ack_out     = ack_q;
    assign addr_o      = addr_q;
    assign addr_valid  = valid_q;
    assign err_illegal = err_ill_q;
    assign err_proto   = err_proto_q;

endmodule
